// File: rtl/branch_resolve_queue.sv
// In-order branch resolution queue: records decode-time predictions, checks them
// against execute outcomes, and emits flush/redirect plus predictor training packets.
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branchD,
  input  logic        stallD,
  input  logic        flushD,
  input  logic [31:0] pcD,
  input  logic        pred_takeD,
  input  logic        pred_localD,
  input  logic        pred_globalD,
  input  logic [31:0] pred_targetD,
  input  logic        resolve_valid,
  input  logic        actual_take,
  input  logic [31:0] actual_target,
  output logic        pred_wrong,
  output logic        flush_pipe,
  output logic [31:0] redirect_pc,
  output logic        update_valid,
  output logic [31:0] update_pc,
  output logic        update_take,
  output logic        update_local_wrong,
  output logic        update_global_wrong,
  output logic        full,
  output logic        resolve_err,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  typedef enum logic {RUN, FLUSH} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic        take;
    logic        predLocal;
    logic        predGlobal;
    logic [31:0] target;
  } entry_t;

  localparam logic [PTR_W:0] FullCount = (PTR_W+1)'(DEPTH);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W:0]   count_q, count_d;
  state_e           state_q, state_d;

  entry_t head;
  logic   resolveGo;
  logic   resolveEmpty;
  logic   mispredictNow;
  logic   enqGo;

  assign full = (count_q == FullCount);

  always_comb begin
    head          = mem_q[rdPtr_q];
    resolveGo     = 1'b0;
    resolveEmpty  = 1'b0;
    mispredictNow = 1'b0;
    enqGo         = 1'b0;
    // The flush cycle swallows resolves: they belong to squashed instructions.
    if (state_q == RUN && resolve_valid) begin
      resolveGo    = (count_q != '0);
      resolveEmpty = (count_q == '0);
    end
    if (resolveGo) begin
      mispredictNow = (head.take != actual_take) ||
                      (head.take && actual_take && (head.target != actual_target));
    end
    enqGo = branchD && !stallD && !flushD && !full && (state_q == RUN) && !mispredictNow;
  end

  always_comb begin
    rdPtr_d = rdPtr_q + PTR_W'(resolveGo);
    wrPtr_d = wrPtr_q + PTR_W'(enqGo);
    count_d = count_q + (PTR_W+1)'(enqGo) - (PTR_W+1)'(resolveGo);
    state_d = state_q;
    // A mispredict discards every younger entry, leaving the queue empty.
    if (mispredictNow) begin
      wrPtr_d = rdPtr_q + PTR_W'(1);
      count_d = '0;
    end
    case (state_q)
      RUN:     if (mispredictNow) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
      state_q <= RUN;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (enqGo) begin
      mem_q[wrPtr_q] <= '{pc: pcD, take: pred_takeD, predLocal: pred_localD,
                          predGlobal: pred_globalD, target: pred_targetD};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pred_wrong          <= 1'b0;
      flush_pipe          <= 1'b0;
      redirect_pc         <= '0;
      update_valid        <= 1'b0;
      update_pc           <= '0;
      update_take         <= 1'b0;
      update_local_wrong  <= 1'b0;
      update_global_wrong <= 1'b0;
      resolve_err         <= 1'b0;
      branch_cnt          <= '0;
      mispred_cnt         <= '0;
    end else begin
      update_valid <= resolveGo;
      pred_wrong   <= mispredictNow;
      flush_pipe   <= mispredictNow;
      if (resolveGo) begin
        update_pc           <= head.pc;
        update_take         <= actual_take;
        update_local_wrong  <= (head.predLocal != actual_take);
        update_global_wrong <= (head.predGlobal != actual_take);
        // Not-taken restart skips the branch and its delay slot.
        redirect_pc         <= actual_take ? actual_target : head.pc + 32'd8;
        branch_cnt          <= branch_cnt + 32'd1;
      end
      if (mispredictNow) begin
        mispred_cnt <= mispred_cnt + 32'd1;
      end
      if (resolveEmpty) begin
        resolve_err <= 1'b1;
      end
    end
  end

endmodule
